instr_rom_fetch: RTL and testbench

Parametrised, synchronous instruction ROM with a valid/ready request/response interface, a response buffer for fetch-stage backpressure, address fault detection, and a flush for redirects. It sits between the PC/fetch unit and the decode stage of the 16-bit CPU. It replaces the fixed 8-word, always-reading instruction ROM with a configurable-depth block that tolerates stalls and redirects.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/rsp_fifo.sv | 52 +++++
 rtl/instr_rom_fetch.sv | 92 +++++++++
 tb/tb_instr_rom_fetch.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fault codes, NOP encoding
// and the built-in boot program for the instruction ROM.
package cpu_pkg;

  localparam logic [1:0] FAULT_NONE     = 2'd0;
  localparam logic [1:0] FAULT_MISALIGN = 2'd1;
  localparam logic [1:0] FAULT_RANGE    = 2'd2;

  localparam logic [15:0] NOP = 16'h0000;

  localparam logic [15:0] PROG_W0   = 16'h1000;
  localparam logic [15:0] PROG_W1   = 16'h6200;
  localparam logic [15:0] PROG_W2   = 16'hBF00;
  localparam logic [15:0] PROG_W3   = 16'h0000;
  localparam logic [15:0] PROG_FILL = 16'h1000;

  // Boot image: four program words, four fill words, zeros beyond.
  function automatic logic [15:0] default_word(input int unsigned idx);
    logic [15:0] w;
    w = 16'h0000;
    if (idx == 0) w = PROG_W0;
    else if (idx == 1) w = PROG_W1;
    else if (idx == 2) w = PROG_W2;
    else if (idx == 3) w = PROG_W3;
    else if (idx < 8) w = PROG_FILL;
    return w;
  endfunction

endpackage

// File: rtl/rsp_fifo.sv
// Synchronous FIFO with occupancy count and flush.
// Flush drops stored entries but keeps a same-edge push.
module rsp_fifo #(
  parameter int W     = 34,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop_data = mem[rd_ptr];

  // Storage write; slot contents need no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointer and count update; flush collapses to the new push only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      wr_ptr <= push ? inc(wr_ptr) : wr_ptr;
      count  <= push ? CW'(1) : '0;
    end else begin
      if (push) wr_ptr <= inc(wr_ptr);
      if (pop) rd_ptr <= inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/instr_rom_fetch.sv
// Instruction ROM with request/response handshake,
// response buffering, fault tagging and redirect flush.
module instr_rom_fetch
  import cpu_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH      = 8,
  parameter int FIFO_DEPTH = 2,
  parameter     INIT_FILE  = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              flush,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_fault,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              fault_sticky
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = DATA_W + 2 + ADDR_W;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [DATA_W-1:0] rom [DEPTH];

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
      assign rom[i] = DATA_W'(default_word(i));
    end
  endgenerate

  logic [ADDR_W-2:0] word_idx;
  logic              in_range;
  logic [1:0]        req_fault;
  logic [DATA_W-1:0] req_data;
  logic              push;
  logic              pop;
  logic [EW-1:0]     head;
  logic [CW-1:0]     count;

  assign word_idx = req_addr[ADDR_W-1:1];
  assign in_range = {1'b0, word_idx} < ADDR_W'(DEPTH);

  // Misalignment takes precedence over range fault.
  always_comb begin
    req_fault = FAULT_NONE;
    priority case (1'b1)
      req_addr[0]: req_fault = FAULT_MISALIGN;
      !in_range:   req_fault = FAULT_RANGE;
      default:     req_fault = FAULT_NONE;
    endcase
  end

  assign req_data = (req_fault == FAULT_NONE)
                  ? rom[word_idx[IW-1:0]]
                  : DATA_W'(NOP);

  assign req_ready = count < CW'(FIFO_DEPTH);
  assign rsp_valid = count != '0;
  assign push      = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;

  rsp_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data ({req_data, req_fault, req_addr}),
    .pop       (pop),
    .pop_data  (head),
    .count     (count)
  );

  assign {rsp_data, rsp_fault, rsp_addr} = rsp_valid ? head : '0;

  // Latch any fault the consumer actually takes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fault_sticky <= 1'b0;
    else if (pop && rsp_fault != FAULT_NONE) fault_sticky <= 1'b1;
  end

endmodule

// File: tb/tb_instr_rom_fetch.sv
// Scoreboard bench for instr_rom_fetch: directed
// scenarios plus randomized traffic against a queue model.
module tb_instr_rom_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic        flush;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_fault;
  logic [15:0] rsp_addr;
  logic        fault_sticky;

  instr_rom_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .flush        (flush),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_fault    (rsp_fault),
    .rsp_addr     (rsp_addr),
    .fault_sticky (fault_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [1:0]  f;
    logic [15:0] a;
  } exp_t;

  exp_t q[$];
  bit   m_sticky = 1'b0;
  bit   done = 1'b0;
  bit   drained = 1'b0;
  int   n_total = 0;
  int   n_pass = 0;

  localparam int CAP = 2;

  function automatic exp_t model(input logic [15:0] a);
    logic [15:0] img [8];
    exp_t e;
    int unsigned w;
    img = '{16'h1000, 16'h6200, 16'hBF00, 16'h0000,
            16'h1000, 16'h1000, 16'h1000, 16'h1000};
    w = a / 2;
    e.a = a;
    if (a % 2 == 1) begin
      e.f = 2'd1;
      e.d = 16'h0000;
    end else if (w >= 8) begin
      e.f = 2'd2;
      e.d = 16'h0000;
    end else begin
      e.f = 2'd0;
      e.d = img[w];
    end
    return e;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
  endtask

  // Monitor: compare away from the edge, then apply the
  // handshakes that the coming rising edge will perform.
  initial begin
    bit pop_m;
    bit push_m;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_req_ready", 32'(req_ready), 1);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_rsp_fault", 32'(rsp_fault), 0);
        chk("rst_rsp_addr", 32'(rsp_addr), 0);
        chk("rst_sticky", 32'(fault_sticky), 0);
        q.delete();
        m_sticky = 1'b0;
      end else begin
        if (q.size() > 0) begin
          chk("rsp_valid", 32'(rsp_valid), 1);
          chk("rsp_data", 32'(rsp_data), 32'(q[0].d));
          chk("rsp_fault", 32'(rsp_fault), 32'(q[0].f));
          chk("rsp_addr", 32'(rsp_addr), 32'(q[0].a));
        end else begin
          chk("rsp_valid_idle", 32'(rsp_valid), 0);
        end
        chk("req_ready", 32'(req_ready), 32'(q.size() < CAP));
        chk("fault_sticky", 32'(fault_sticky), 32'(m_sticky));
        pop_m  = (q.size() > 0) && rsp_ready;
        push_m = req_valid && (q.size() < CAP);
        if (pop_m) begin
          if (q[0].f != 2'd0) m_sticky = 1'b1;
          void'(q.pop_front());
        end
        if (flush) q.delete();
        if (push_m) q.push_back(model(req_addr));
        if (done && !drained) begin
          chk("drain_empty", 32'(q.size()), 0);
          drained = 1'b1;
        end
      end
    end
  end

  task automatic cyc(input bit v, input logic [15:0] a,
                     input bit rr, input bit fl);
    req_valid = v;
    req_addr  = a;
    rsp_ready = rr;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0);
  endtask

  // Hold a request until the DUT accepts it (bounded).
  task automatic send(input logic [15:0] a, input bit rr);
    bit acc;
    req_valid = 1'b1;
    req_addr  = a;
    rsp_ready = rr;
    flush     = 1'b0;
    for (int i = 0; i < 10; i++) begin
      acc = req_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = 16'h0;
    flush     = 1'b0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    send(16'h0000, 1'b1); idle(1);
    send(16'h0002, 1'b1); idle(1);
    send(16'h0004, 1'b1); idle(2);

    for (int i = 0; i < 8; i++) send(16'(i * 2), 1'b1);
    idle(3);

    for (int i = 0; i < 4; i++) cyc(1'b1, 16'(i * 2), 1'b0, 1'b0);
    idle(4);

    send(16'h0003, 1'b1); idle(2);
    send(16'h0010, 1'b1); idle(2);

    cyc(1'b1, 16'h0008, 1'b0, 1'b0);
    cyc(1'b1, 16'h000A, 1'b0, 1'b0);
    cyc(1'b1, 16'h0006, 1'b0, 1'b1);
    send(16'h0006, 1'b1);
    idle(3);

    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0,
          16'($urandom_range(0, 21)),
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 15) == 0);
    idle(4);

    send(16'h0003, 1'b1); idle(1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'h0002, 1'b0, 1'b0);
    req_valid = 1'b0;
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(16'h0002, 1'b1);
    idle(6);

    done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (drained) break;
      @(posedge clk);
    end
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
